// File: rtl/dmem_store_buffer_if.sv
// Bus bundle for the data-memory store buffer.
// Groups the core load/store port and the data-memory read/write ports.
// slave  : the view used by dmem_store_buffer itself.
// master : the view used by the environment (core + memory model).
interface dmem_store_buffer_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // Core side.
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_we;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;

    // Memory read port.
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    // Memory write channel (valid/ready).
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wvalid;
    logic              mem_wready;

    modport slave (
        input  core_addr,
        input  core_wdata,
        input  core_we,
        output core_rdata,
        output core_stall,
        output mem_raddr,
        input  mem_rdata,
        output mem_waddr,
        output mem_wdata,
        output mem_wvalid,
        input  mem_wready
    );

    modport master (
        output core_addr,
        output core_wdata,
        output core_we,
        input  core_rdata,
        input  core_stall,
        input  mem_raddr,
        output mem_rdata,
        input  mem_waddr,
        input  mem_wdata,
        input  mem_wvalid,
        output mem_wready
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write store buffer for the core data port.
//
// Stores are accepted in a single cycle into a circular FIFO of doubleword
// entries and drained to memory over a valid/ready write channel. Loads go
// straight to memory combinationally, with store-to-load forwarding from the
// youngest queued entry that matches the doubleword address.
//
// Optional build macro:
//   STB_COALESCE_EN - a store hitting the youngest entry (with at least two
//                     entries queued, so never the head) overwrites that
//                     entry's data instead of allocating a new one.
//
// DEPTH must be a power of two and at least 2, so the pointers wrap for free.
module dmem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    dmem_store_buffer_if.slave           bus,
    output logic [$clog2(DEPTH+1)-1:0]   sb_count,
    output logic                         sb_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TAG_W = ADDR_W - 3;

    // Entry storage: doubleword address tag and data.
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    // FIFO bookkeeping.
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  head_d;
    logic [PTR_W-1:0]  tail_q;
    logic [PTR_W-1:0]  tail_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    // Combinational helpers.
    logic [TAG_W-1:0]  core_tag_s;
    logic [PTR_W-1:0]  youngest_s;
    logic              stall_s;
    logic              push_s;
    logic              pop_s;
    logic              alloc_s;
    logic              coalesce_s;
    logic [DEPTH-1:0]  match_s;
    logic              fwd_hit_s;
    logic [DATA_W-1:0] fwd_data_s;

    // The byte offset inside a doubleword plays no part in matching or draining.
    logic              unused_addr_lsb_s;
    assign unused_addr_lsb_s = ^bus.core_addr[2:0];

    assign core_tag_s = bus.core_addr[ADDR_W-1:3];
    assign youngest_s = tail_q - PTR_W'(1);

    // Stall comes only from the registered count; a pop this cycle does not relieve it.
    assign stall_s = (count_q == CNT_W'(DEPTH));
    assign push_s  = bus.core_we && !stall_s;
    assign pop_s   = (count_q != CNT_W'(0)) && bus.mem_wready;

`ifdef STB_COALESCE_EN
    // With two or more entries the youngest is never the head, so the entry
    // currently presented on the write channel can never be rewritten.
    assign coalesce_s = push_s
                        && (count_q >= CNT_W'(2))
                        && (tag_q[youngest_s] == core_tag_s);
`else
    assign coalesce_s = 1'b0;
`endif

    assign alloc_s = push_s && !coalesce_s;

    // Next entry contents: allocate at tail, or merge into the youngest entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tag_d[i]  = tag_q[i];
            data_d[i] = data_q[i];
        end
        case ({alloc_s, coalesce_s})
            2'b10: begin
                tag_d[tail_q]  = core_tag_s;
                data_d[tail_q] = bus.core_wdata;
            end
            2'b01: begin
                data_d[youngest_s] = bus.core_wdata;
            end
            default: begin
                tag_d[tail_q] = tag_q[tail_q];
            end
        endcase
    end

    // Next pointers and occupancy; simultaneous allocate and pop leave count unchanged.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        if (alloc_s) begin
            tail_d = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        case ({alloc_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Youngest-first forwarding search: walk from tail-1 backwards over the valid entries.
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        match_s    = {DEPTH{1'b0}};
        fwd_data_s = {DATA_W{1'b0}};
        idx_v      = youngest_s;
        // Oldest candidate first so that the youngest match is the last one applied.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx_v      = youngest_s - PTR_W'(i);
            match_s[i] = (CNT_W'(i) < count_q) && (tag_q[idx_v] == core_tag_s);
            fwd_data_s = match_s[i] ? data_q[idx_v] : fwd_data_s;
        end
    end

    assign fwd_hit_s = |match_s;

    // Load path and write channel are pure functions of the registered state.
    assign bus.mem_raddr  = bus.core_addr;
    assign bus.core_rdata = fwd_hit_s ? fwd_data_s : bus.mem_rdata;
    assign bus.core_stall = stall_s;
    assign bus.mem_wvalid = (count_q != CNT_W'(0));
    assign bus.mem_waddr  = {tag_q[head_q], 3'b000};
    assign bus.mem_wdata  = data_q[head_q];

    assign sb_count = count_q;
    assign sb_empty = (count_q == CNT_W'(0));

    // Pointer and occupancy registers; reset discards every pending store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= {TAG_W{1'b0}};
                data_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer.
// A queue-based model tracks the pending stores and a small memory array; a
// compare process checks every DUT output against it on each falling edge.
// Directed sequences add hand-computed literal expectations, followed by a
// randomized phase. Honours STB_COALESCE_EN the same way as the design.
module tb_dmem_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 64;
    localparam int DW    = 64;

    typedef struct packed {
        logic [AW-4:0] tag;
        logic [DW-1:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  sb_count;
    logic        sb_empty;

    int total = 0;
    int bad   = 0;

    ent_t        mq[$];
    logic [DW-1:0] mem_arr [64];

    dmem_store_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sb_count (sb_count),
        .sb_empty (sb_empty)
    );

    always #5 clk = ~clk;

    // Memory read port: combinational from the read address.
    assign bus.mem_rdata = mem_arr[bus.mem_raddr[8:3]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [63:0] a, input logic [63:0] d, input logic wr);
        bus.core_we    = we;
        bus.core_addr  = a;
        bus.core_wdata = d;
        bus.mem_wready = wr;
    endtask

    task automatic drain_all();
        drive(1'b0, 64'h0, 64'h0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (sb_empty === 1'b1) break;
            tick();
        end
        chk("drain_timeout", 64'(sb_empty), 64'h1);
    endtask

    // Reference model: pending-store queue plus memory, updated on each clock edge.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
            end else begin
                bit full, do_push, do_pop, coal;
                full    = (mq.size() == DEPTH);
                do_push = bus.core_we && !full;
                do_pop  = (mq.size() != 0) && bus.mem_wready;
                coal    = 1'b0;
`ifdef STB_COALESCE_EN
                if (do_push && mq.size() >= 2 && mq[mq.size()-1].tag == bus.core_addr[AW-1:3])
                    coal = 1'b1;
`endif
                if (do_push) begin
                    if (coal) mq[mq.size()-1].data = bus.core_wdata;
                    else      mq.push_back('{tag: bus.core_addr[AW-1:3], data: bus.core_wdata});
                end
                if (do_pop) begin
                    mem_arr[mq[0].tag[5:0]] = mq[0].data;
                    void'(mq.pop_front());
                end
            end
        end
    end

    // Compare process: every output against the model on each falling edge.
    initial begin
        forever begin
            logic [DW-1:0] exp_rd;
            @(negedge clk);
            exp_rd = mem_arr[bus.core_addr[8:3]];
            foreach (mq[i]) begin
                if (mq[i].tag == bus.core_addr[AW-1:3]) exp_rd = mq[i].data;
            end
            chk("m_stall",  64'(bus.core_stall), 64'(mq.size() == DEPTH));
            chk("m_wvalid", 64'(bus.mem_wvalid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("m_waddr", bus.mem_waddr, {mq[0].tag, 3'b000});
                chk("m_wdata", bus.mem_wdata, mq[0].data);
            end
            chk("m_count",  64'(sb_count), 64'(mq.size()));
            chk("m_empty",  64'(sb_empty), 64'(mq.size() == 0));
            chk("m_raddr",  bus.mem_raddr, bus.core_addr);
            chk("m_rdata",  bus.core_rdata, exp_rd);
        end
    end

    // Directed sequences followed by random stimulus.
    initial begin
        logic [63:0] ea [3];
        logic [63:0] ed [3];
        int          n;
        int          thr;

        for (int i = 0; i < 64; i++) mem_arr[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 17);
        drive(1'b0, 64'h0, 64'h0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty",  64'(sb_empty), 64'h1);
        chk("rst_count",  64'(sb_count), 64'h0);
        chk("rst_wvalid", 64'(bus.mem_wvalid), 64'h0);
        chk("rst_stall",  64'(bus.core_stall), 64'h0);
        rst = 1'b0;
        tick();

        // Single store, drained immediately.
        drive(1'b1, 64'h10, 64'h5, 1'b1);
        tick();
        drive(1'b0, 64'h0, 64'h0, 1'b1);
        chk("t1_wvalid", 64'(bus.mem_wvalid), 64'h1);
        chk("t1_waddr",  bus.mem_waddr, 64'h10);
        chk("t1_wdata",  bus.mem_wdata, 64'h5);
        tick();
        chk("t1_empty",  64'(sb_empty), 64'h1);

        // Fill to full, ignored fifth store, in-order drain.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(i * 8), 64'(256 + i), 1'b0);
            tick();
        end
        chk("t2_count", 64'(sb_count), 64'h4);
        chk("t2_stall", 64'(bus.core_stall), 64'h1);
        drive(1'b1, 64'h20, 64'hDEAD, 1'b0);
        tick();
        chk("t2_count5", 64'(sb_count), 64'h4);
        drive(1'b0, 64'h0, 64'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_addr", bus.mem_waddr, 64'(i * 8));
            chk("t2_drain_data", bus.mem_wdata, 64'(256 + i));
            tick();
            if (i == 0) chk("t2_stall_drop", 64'(bus.core_stall), 64'h0);
        end
        chk("t2_empty", 64'(sb_empty), 64'h1);

        // Forwarding picks the youngest match; non-matching load goes to memory.
        drive(1'b1, 64'h40, 64'hA, 1'b0);
        tick();
        drive(1'b1, 64'h40, 64'hB, 1'b0);
        tick();
        drive(1'b0, 64'h44, 64'h0, 1'b0);
        #1;
        chk("t3_fwd", bus.core_rdata, 64'hB);
        drive(1'b0, 64'h48, 64'h0, 1'b0);
        #1;
        chk("t3_mem", bus.core_rdata, 64'hA5A5_0000_0000_0000 | 64'(9 * 17));
        drain_all();

        // Same-cycle store is not forwarded.
        mem_arr[16] = 64'h1;
        drive(1'b1, 64'h80, 64'h7, 1'b0);
        #1;
        chk("t4_same", bus.core_rdata, 64'h1);
        tick();
        drive(1'b0, 64'h80, 64'h0, 1'b0);
        #1;
        chk("t4_next", bus.core_rdata, 64'h7);
        drain_all();

        // Asynchronous reset mid-cycle discards pending stores.
        drive(1'b0, 64'h0, 64'h0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'(64'h100 + i * 8), 64'(64'h900 + i), 1'b0);
            tick();
        end
        drive(1'b0, 64'h0, 64'h0, 1'b0);
        chk("t5_count_pre", 64'(sb_count), 64'h3);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_wvalid", 64'(bus.mem_wvalid), 64'h0);
        chk("t5_count",  64'(sb_count), 64'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        drive(1'b0, 64'h0, 64'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_nowrite", 64'(bus.mem_wvalid), 64'h0);
        end

        // Coalescing (or not) of a repeated store to the youngest entry.
        drive(1'b1, 64'h0, 64'h1, 1'b0);
        tick();
        drive(1'b1, 64'h8, 64'h2, 1'b0);
        tick();
        drive(1'b1, 64'h8, 64'h3, 1'b0);
        tick();
        drive(1'b0, 64'h0, 64'h0, 1'b0);
`ifdef STB_COALESCE_EN
        n = 2;
        ea[0] = 64'h0; ed[0] = 64'h1;
        ea[1] = 64'h8; ed[1] = 64'h3;
        ea[2] = 64'h0; ed[2] = 64'h0;
`else
        n = 3;
        ea[0] = 64'h0; ed[0] = 64'h1;
        ea[1] = 64'h8; ed[1] = 64'h2;
        ea[2] = 64'h8; ed[2] = 64'h3;
`endif
        chk("t6_count", 64'(sb_count), 64'(n));
        drive(1'b0, 64'h0, 64'h0, 1'b1);
        for (int i = 0; i < n; i++) begin
            chk("t6_addr", bus.mem_waddr, ea[i]);
            chk("t6_data", bus.mem_wdata, ed[i]);
            tick();
        end
        chk("t6_empty", 64'(sb_empty), 64'h1);

        // Randomized traffic with alternating back-pressure phases.
        for (int c = 0; c < 3000; c++) begin
            thr = (((c / 250) % 2) == 1) ? 30 : 85;
            drive(1'($urandom_range(0, 1)),
                  {55'd0, 6'($urandom_range(0, 15)), 3'($urandom)},
                  {$urandom, $urandom},
                  ($urandom_range(0, 99) < thr));
            tick();
        end
        drain_all();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Posted-write store buffer between the core's data-memory port (addr/wdata/we/rdata) and the data memory.
- Stores are accepted in one cycle, queued in a FIFO of doubleword entries and drained to memory over a valid/ready write channel.
- Loads read memory combinationally, with store-to-load forwarding from the queued entries.
- Lets the core run at full rate against a write port that can back-pressure.

Parameters:
- DEPTH, 4: number of store entries; power of 2, minimum 2.
- ADDR_W, 64: address width.
- DATA_W, 64: data width; one entry holds one doubleword.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- core_addr  in  ADDR_W  load/store byte address; bits [2:0] ignored (doubleword granularity).
- core_wdata  in  DATA_W  store data.
- core_we  in  1  store request this cycle.
- core_rdata  out  DATA_W  load data, combinational.
- core_stall  out  1  buffer full; core must hold the store and retry.
- mem_raddr  out  ADDR_W  memory read address, equal to core_addr.
- mem_rdata  in  DATA_W  memory read data, combinational from mem_raddr.
- mem_waddr  out  ADDR_W  head entry address.
- mem_wdata  out  DATA_W  head entry data.
- mem_wvalid  out  1  head entry valid.
- mem_wready  in  1  memory accepts the write.
- sb_count  out  $clog2(DEPTH+1)  occupancy.
- sb_empty  out  1  no pending stores; used for fence/drain.

Behaviour:
- Storage: circular FIFO with head pointer, tail pointer and count register. Each entry holds {addr[ADDR_W-1:3], data}.
- Reset (async, any time, including mid-drain):
  - count=0, head=tail=0.
  - mem_wvalid=0, core_stall=0, sb_empty=1, sb_count=0.
  - All pending stores are discarded.
  - mem_waddr/mem_wdata are don't-care while mem_wvalid=0.
- Enqueue:
  - Occurs when core_we=1 and core_stall=0.
  - Writes entry[tail], tail+1 (wraps modulo DEPTH).
  - Entry is visible to forwarding and drain from the next cycle.
- core_stall is exactly (count==DEPTH), combinational from registered count.
  - While stalled, core_we is ignored; no entry is written.
  - A pop in the same cycle does not clear the stall that cycle.
- Drain:
  - mem_wvalid = (count!=0).
  - mem_waddr = {entry[head].addr, 3'b000}; mem_wdata = entry[head].data.
  - Pop on mem_wvalid && mem_wready: head+1 (wraps).
  - Once asserted, mem_wvalid/mem_waddr/mem_wdata stay stable until accepted. The head entry is never modified.
- Simultaneous enqueue and pop: count unchanged; both pointers advance.
- Load path:
  - mem_raddr = core_addr.
  - core_rdata = data of the youngest valid entry whose addr matches core_addr[ADDR_W-1:3]; otherwise mem_rdata.
  - The youngest-first priority search starts at tail-1 and wraps.
  - A store enqueued in the same cycle is not forwarded: the load sees pre-store data.
  - An entry being popped this cycle still forwards.
- sb_empty = (count==0); sb_count = count.
- Latency: store to mem_wvalid is 1 cycle minimum when the buffer was empty. Load is 0 cycles.

Optional Feature:
- Macro: STB_COALESCE_EN.
- Defined:
  - An accepted store whose doubleword address equals the youngest entry (tail-1), with count>=2, overwrites that entry's data in place.
  - No new entry is allocated; tail and count are unchanged.
  - The head entry is never coalesced, even when count==1.
  - Stall rule is unchanged.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset then store 0x5 to 0x10 with mem_wready=1 -> next cycle mem_wvalid=1, mem_waddr=0x10, mem_wdata=0x5; popped that cycle; following cycle sb_empty=1.
- mem_wready=0, 4 stores to 0x0/0x8/0x10/0x18 -> sb_count=4, core_stall=1; 5th store to 0x20 ignored; raise mem_wready -> drains in order 0x0..0x18, one per cycle, stall drops after first pop.
- mem_wready=0, store 0xA then 0xB to 0x40; load 0x44 -> core_rdata=0xB (youngest, low bits ignored). Load 0x48 -> core_rdata equals mem_rdata model value.
- Store 0x7 to 0x80 and load 0x80 in the same cycle, memory holds 0x1 -> core_rdata=0x1; next cycle load 0x80 -> 0x7.
- mem_wready=0, 3 entries queued; assert rst mid-cycle -> mem_wvalid, sb_count drop to 0 immediately (async); after release no writes are issued.
- STB_COALESCE_EN defined, mem_wready=0: stores 0x1@0x0, 0x2@0x8, 0x3@0x8 -> sb_count=2, drain yields 0x1@0x0 then 0x3@0x8. Undefined: sb_count=3, drain yields 0x1, 0x2, 0x3.
